// File: rtl/simple_decrypt.sv
// Decrypt engine for the 64-bit / 128-bit-key XOR block transform: pt = ct ^ K_hi ^ K_lo after ROUNDS cycles.
// Optional feature macro KEY_ZEROIZE_EN: the key, work and pt_data registers are wiped after each block.
module simple_decrypt #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  output logic         key_valid,
  output logic         key_err,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [63:0]  ct_data,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [63:0]  pt_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [63:0]  work;
  logic [3:0]   cnt;
`ifdef KEY_ZEROIZE_EN
  logic         zero_pend;
`endif

  assign ct_ready = (state == IDLE) && key_valid && !key_load;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      key_valid <= 1'b0;
      work      <= '0;
      cnt       <= '0;
      pt_data   <= '0;
      pt_valid  <= 1'b0;
      key_err   <= 1'b0;
`ifdef KEY_ZEROIZE_EN
      zero_pend <= 1'b0;
`endif
    end else begin
      key_err <= 1'b0;
`ifdef KEY_ZEROIZE_EN
      // pt_data is wiped one cycle after the handshake so the consumer sees the word on the handshake edge
      if (zero_pend) begin
        pt_data   <= '0;
        zero_pend <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (key_load) begin
            key_reg   <= key_in;
            key_valid <= 1'b1;
          end else if (ct_valid && key_valid) begin
            work  <= ct_data ^ key_reg[127:64];
            cnt   <= 4'(ROUNDS);
            state <= RUN;
          end else if (ct_valid) begin
            key_err <= 1'b1;
          end
        end
        RUN: begin
          if (key_load) key_err <= 1'b1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            pt_data  <= work ^ key_reg[63:0];
            pt_valid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (key_load) key_err <= 1'b1;
          if (pt_ready) begin
            pt_valid <= 1'b0;
            state    <= IDLE;
`ifdef KEY_ZEROIZE_EN
            key_reg   <= '0;
            key_valid <= 1'b0;
            work      <= '0;
            zero_pend <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_decrypt.sv
// Directed self-checking bench for simple_decrypt (ROUNDS=10); define KEY_ZEROIZE_EN to exercise zeroization.
module tb_simple_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_err;
  logic         ct_valid;
  logic         ct_ready;
  logic [63:0]  ct_data;
  logic         pt_valid;
  logic         pt_ready;
  logic [63:0]  pt_data;
  logic         busy;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY  = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [63:0]  PT1  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0]  PT2  = 64'hFFFFFFFF21524110;

  simple_decrypt #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .key_valid(key_valid), .key_err(key_err), .ct_valid(ct_valid),
    .ct_ready(ct_ready), .ct_data(ct_data), .pt_valid(pt_valid),
    .pt_ready(pt_ready), .pt_data(pt_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key_in   = k;
    tick();
    key_load = 1'b0;
    #1;
  endtask

  task automatic accept(input logic [63:0] ct);
    ct_valid = 1'b1;
    ct_data  = ct;
    #1;
    chk("ct_ready_before_accept", 64'(ct_ready), 64'd1);
    tick();
    ct_valid = 1'b0;
    ct_data  = 64'h5A5A5A5A5A5A5A5A;
  endtask

  // 9 further edges after accept: still low; 10th edge: pt_valid rises
  task automatic run_to_pt(input string tag, input logic [63:0] exp);
    for (int i = 1; i < 10; i++) tick();
    chk({tag, "_pv_early"}, 64'(pt_valid), 64'd0);
    tick();
    chk({tag, "_pv"}, 64'(pt_valid), 64'd1);
    chk({tag, "_pt"}, pt_data, exp);
  endtask

  task automatic handshake(input string tag);
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    #1;
    chk({tag, "_pv_drop"}, 64'(pt_valid), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; key_in = '0; ct_valid = 1'b0;
    ct_data = '0; pt_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_pt_valid", 64'(pt_valid), 64'd0);
    chk("rst_pt_data", pt_data, 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_key_err", 64'(key_err), 64'd0);
    chk("rst_ct_ready", 64'(ct_ready), 64'd0);

    // T3: ciphertext without a key
    ct_valid = 1'b1;
    ct_data  = 64'h1234;
    #1;
    chk("t3_ct_ready", 64'(ct_ready), 64'd0);
    tick();
    chk("t3_key_err1", 64'(key_err), 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);
    tick();
    chk("t3_key_err2", 64'(key_err), 64'd1);
    ct_valid = 1'b0;
    tick();
    chk("t3_key_err_clr", 64'(key_err), 64'd0);

    // key_load blocks ct_ready combinationally
    key_load = 1'b1;
    key_in   = KEY;
    #1;
    chk("ld_ct_ready", 64'(ct_ready), 64'd0);
    key_load = 1'b0;
    #1;

    // T1 basic
    load_key(KEY);
    chk("t1_key_valid", 64'(key_valid), 64'd1);
    accept(64'h0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ct_ready_run", 64'(ct_ready), 64'd0);
    run_to_pt("t1", PT1);
    handshake("t1");
`ifndef KEY_ZEROIZE_EN
    chk("t1_pt_keep", pt_data, PT1);
    tick();
    chk("t1_pt_keep2", pt_data, PT1);
    chk("t1_key_persist", 64'(key_valid), 64'd1);
`endif

    // T2 backpressure
    load_key(KEY);
    accept(64'h00000000DEADBEEF);
    run_to_pt("t2", PT2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_pv", 64'(pt_valid), 64'd1);
      chk("t2_hold_pt", pt_data, PT2);
      chk("t2_hold_ct_ready", 64'(ct_ready), 64'd0);
    end
    handshake("t2");

    // T4 key_load during RUN is rejected
    load_key(KEY);
    accept(64'h0);
    tick(); tick();
    key_load = 1'b1;
    key_in   = '0;
    tick();
    key_load = 1'b0;
    chk("t4_key_err", 64'(key_err), 64'd1);
    for (int i = 4; i < 10; i++) tick();
    chk("t4_pv_early", 64'(pt_valid), 64'd0);
    tick();
    chk("t4_pv", 64'(pt_valid), 64'd1);
    chk("t4_pt", pt_data, PT1);
    handshake("t4");
`ifndef KEY_ZEROIZE_EN
    // key_reg still holds KEY: a block without reloading gives the T1 result
    accept(64'h0);
    run_to_pt("t4b", PT1);
    handshake("t4b");
`endif

    // T5 reset mid-RUN
    load_key(KEY);
    accept(64'h0);
    for (int i = 1; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_key_valid", 64'(key_valid), 64'd0);
    chk("t5_pt_data", pt_data, 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (pt_valid) seen++;
      end
      chk("t5_pv_never", 64'(seen), 64'd0);
    end

`ifdef KEY_ZEROIZE_EN
    // T6 zeroization
    load_key(KEY);
    accept(64'h0);
    run_to_pt("t6", PT1);
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    #1;
    chk("t6_key_valid", 64'(key_valid), 64'd0);
    chk("t6_ct_ready", 64'(ct_ready), 64'd0);
    chk("t6_pt_hs", pt_data, PT1);
    tick();
    chk("t6_pt_zero", pt_data, 64'd0);
    ct_valid = 1'b1;
    tick();
    ct_valid = 1'b0;
    chk("t6_key_err", 64'(key_err), 64'd1);
    chk("t6_not_busy", 64'(busy), 64'd0);
    load_key(KEY);
    accept(64'h00000000DEADBEEF);
    run_to_pt("t6b", PT2);
    handshake("t6b");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
